alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 60 ++++++
 rtl/alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Groups the request and response channels of the two requesters that share
// one ALU through alu_arbiter.
//
// Signals
//   reqN_valid / reqN_ready   request handshake for requester N (N = 0, 1)
//   reqN_single               single-operand operation select
//   reqN_op                   ALU operator code
//   reqN_a / reqN_b           operands (value1 / value2)
//   rspN_valid / rspN_ready   response handshake for requester N
//   rsp_data                  captured ALU result (shared by both requesters)
//   rsp_flags                 captured {old_sign, carry, overflow, zero, negative}
//   rsp_wb                    result is to be written back
//
// Modports
//   master : requester side (drives requests, consumes responses)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface alu_arbiter_if;

    logic        req0_valid;
    logic        req0_ready;
    logic        req0_single;
    logic [3:0]  req0_op;
    logic [15:0] req0_a;
    logic [15:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic        req1_single;
    logic [3:0]  req1_op;
    logic [15:0] req1_a;
    logic [15:0] req1_b;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic        rsp_wb;

    modport master (
        output req0_valid, req0_single, req0_op, req0_a, req0_b,
        output req1_valid, req1_single, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        output rsp0_ready, rsp1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_flags, rsp_wb
    );

    modport slave (
        input  req0_valid, req0_single, req0_op, req0_a, req0_b,
        input  req1_valid, req1_single, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        input  rsp0_ready, rsp1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_flags, rsp_wb
    );

endinterface : alu_arbiter_if

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters. A request is accepted in IDLE by a
// round-robin arbiter, driven onto the ALU for exactly one cycle (EXEC), the
// registered ALU result is captured one cycle later (CAPT), and the response
// is held for the owning requester until it is consumed (RESP).
//
// Outside EXEC the ALU is driven with a single-operand IDLE_OP that the ALU
// treats as a no-op for its carry, so carry chains (SBC -> ADC) survive the
// idle gaps between requests.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   bus            alu_arbiter_if.slave : request/response channels
//   alu_single     registered ALU single-operand select
//   alu_operator   registered ALU operator code
//   alu_value1/2   registered ALU operands
//   alu_bus_out    ALU result (registered inside the ALU)
//   alu_flags      ALU flags {old_sign, carry, overflow, zero, negative}
//
// Parameters
//   IDLE_OP        operator driven whenever no request is executing
//   OP_CMP         compare operator; its result is not written back
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter logic [3:0] IDLE_OP = 4'hF,
    parameter logic [3:0] OP_CMP  = 4'h7
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic         alu_single,
    output logic [3:0]   alu_operator,
    output logic [15:0]  alu_value1,
    output logic [15:0]  alu_value2,
    input  logic [15:0]  alu_bus_out,
    input  logic [4:0]   alu_flags
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;

    // prio_r names the requester that wins when both are valid; it always
    // points at the requester that was not served last.
    logic        prio_r;
    logic        owner_r;
    logic [3:0]  op_r;
    logic        single_r;

    logic        rsp0_valid_r;
    logic        rsp1_valid_r;
    logic [15:0] rsp_data_r;
    logic [4:0]  rsp_flags_r;
    logic        rsp_wb_r;

    logic        grant_valid_s;
    logic        grant_id_s;
    logic        accept_s;
    logic        rsp_done_s;

    logic        sel_single_s;
    logic [3:0]  sel_op_s;
    logic [15:0] sel_a_s;
    logic [15:0] sel_b_s;

    // Round-robin grant decision from the current request valids.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = prio_r;
        end else if (bus.req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (bus.req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Accept only in IDLE; valids seen in any other state are ignored.
    always_comb begin
        accept_s = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = grant_valid_s;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Request ready is combinational; rst_n gating keeps it low while reset
    // is asserted even though the state register already reads IDLE.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if (rst_n && accept_s) begin
            bus.req0_ready = ~grant_id_s;
            bus.req1_ready = grant_id_s;
        end else begin
            bus.req0_ready = 1'b0;
            bus.req1_ready = 1'b0;
        end
    end

    // Field mux of the granted request.
    always_comb begin
        sel_single_s = 1'b0;
        sel_op_s     = 4'h0;
        sel_a_s      = 16'h0000;
        sel_b_s      = 16'h0000;
        if (grant_id_s) begin
            sel_single_s = bus.req1_single;
            sel_op_s     = bus.req1_op;
            sel_a_s      = bus.req1_a;
            sel_b_s      = bus.req1_b;
        end else begin
            sel_single_s = bus.req0_single;
            sel_op_s     = bus.req0_op;
            sel_a_s      = bus.req0_a;
            sel_b_s      = bus.req0_b;
        end
    end

    // Response consumed: only the owner's rsp_ready counts.
    always_comb begin
        rsp_done_s = 1'b0;
        if (state_r == ST_RESP) begin
            rsp_done_s = owner_r ? bus.rsp1_ready : bus.rsp0_ready;
        end else begin
            rsp_done_s = 1'b0;
        end
    end

    // Next-state logic of the IDLE/EXEC/CAPT/RESP sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_CAPT;
            ST_CAPT: state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Arbitration pointer and owner/op bookkeeping, updated only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r   <= 1'b0;
            owner_r  <= 1'b0;
            op_r     <= IDLE_OP;
            single_r <= 1'b1;
        end else if (accept_s) begin
            prio_r   <= ~grant_id_s;
            owner_r  <= grant_id_s;
            op_r     <= sel_op_s;
            single_r <= sel_single_s;
        end else begin
            prio_r   <= prio_r;
            owner_r  <= owner_r;
            op_r     <= op_r;
            single_r <= single_r;
        end
    end

    // ALU drive: load on accept, fall back to the idle no-op after the single
    // EXEC cycle so the ALU sees the request exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_single   <= 1'b1;
            alu_operator <= IDLE_OP;
            alu_value1   <= 16'h0000;
            alu_value2   <= 16'h0000;
        end else if (accept_s) begin
            alu_single   <= sel_single_s;
            alu_operator <= sel_op_s;
            alu_value1   <= sel_a_s;
            alu_value2   <= sel_b_s;
        end else if (state_r == ST_EXEC) begin
            alu_single   <= 1'b1;
            alu_operator <= IDLE_OP;
            alu_value1   <= 16'h0000;
            alu_value2   <= 16'h0000;
        end else begin
            alu_single   <= alu_single;
            alu_operator <= alu_operator;
            alu_value1   <= alu_value1;
            alu_value2   <= alu_value2;
        end
    end

    // Response capture in CAPT; data held stable through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r  <= 16'h0000;
            rsp_flags_r <= 5'b00000;
            rsp_wb_r    <= 1'b0;
        end else if (state_r == ST_CAPT) begin
            rsp_data_r  <= alu_bus_out;
            rsp_flags_r <= alu_flags;
            rsp_wb_r    <= (op_r != OP_CMP) || single_r;
        end else begin
            rsp_data_r  <= rsp_data_r;
            rsp_flags_r <= rsp_flags_r;
            rsp_wb_r    <= rsp_wb_r;
        end
    end

    // Per-requester response valid: raised entering RESP, dropped on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else if (state_r == ST_CAPT) begin
            rsp0_valid_r <= ~owner_r;
            rsp1_valid_r <= owner_r;
        end else if (rsp_done_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else begin
            rsp0_valid_r <= rsp0_valid_r;
            rsp1_valid_r <= rsp1_valid_r;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_flags  = rsp_flags_r;
    assign bus.rsp_wb     = rsp_wb_r;

endmodule : alu_arbiter
